hex_seg_display: RTL and testbench



---
 rtl/hex_seg_display_if.sv | 35 +++
 rtl/hex_seg_display.sv | 118 +++++++++++
 tb/tb_hex_seg_display.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_seg_display_if.sv
// Bus bundle for hex_seg_display: load strobe, hex data, display controls and segment outputs.
// HEX_SEG_DISPLAY_DP_EN adds the per-digit decimal-point input dp_in.
interface hex_seg_display_if #(
  parameter int unsigned NUM_DIGITS = 2
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic                      blank_lz;
  logic                      blink_en;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [8*NUM_DIGITS-1:0]   seg_out;
`ifdef HEX_SEG_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0]     dp_in;

  modport master (
    output load, data_in, blank_lz, blink_en, blink_mask, dp_in,
    input  seg_out
  );

  modport slave (
    input  load, data_in, blank_lz, blink_en, blink_mask, dp_in,
    output seg_out
  );
`else
  modport master (
    output load, data_in, blank_lz, blink_en, blink_mask,
    input  seg_out
  );

  modport slave (
    input  load, data_in, blank_lz, blink_en, blink_mask,
    output seg_out
  );
`endif
endinterface

// File: rtl/hex_seg_display.sv
// NUM_DIGITS-digit active-low 7-segment hex display with leading-zero blanking and per-digit blink.
// Optional HEX_SEG_DISPLAY_DP_EN: per-digit decimal point captured alongside data_in.
module hex_seg_display #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  hex_seg_display_if.slave  bus
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic {
    PHASE_HIDDEN  = 1'b0,
    PHASE_VISIBLE = 1'b1
  } phase_e;

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  phase_e                  phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_run;
  logic [7:0]              code;
`ifdef HEX_SEG_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q;
`endif

  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    unique case (d)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Blink prescaler: counter and phase only run while blink_en is held.
  always_comb begin
    cnt_d   = '0;
    phase_d = PHASE_VISIBLE;
    if (bus.blink_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero while
  // every digit above it (and itself) is zero. Digit 0 is always shown.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    seg_d    = '1;
    code     = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run & (data_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz[NUM_DIGITS-1-k] = zero_run & (k != NUM_DIGITS-1);
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      code = glyph(data_q[4*i +: 4]);
`ifdef HEX_SEG_DISPLAY_DP_EN
      code[7] = ~dp_q[i];
`endif
      if ((phase_q == PHASE_HIDDEN) && bus.blink_mask[i]) begin
        code = '1;
      end else if (bus.blank_lz && lz[i]) begin
        code = '1;
      end
      seg_d[8*i +: 8] = code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      phase_q <= PHASE_VISIBLE;
      seg_q   <= '1;
`ifdef HEX_SEG_DISPLAY_DP_EN
      dp_q    <= '0;
`endif
    end else begin
      if (bus.load) begin
        data_q <= bus.data_in;
`ifdef HEX_SEG_DISPLAY_DP_EN
        dp_q   <= bus.dp_in;
`endif
      end
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_hex_seg_display.sv
// Scoreboard bench for hex_seg_display: a 2-digit/BLINK_DIV=4 instance and a 4-digit/BLINK_DIV=1 instance.
module tb_hex_seg_display;

  logic clk;
  logic rst;
  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    int unsigned due;
    int          dut;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [31:0] act;

  hex_seg_display_if #(.NUM_DIGITS(2)) ifa ();
  hex_seg_display_if #(.NUM_DIGITS(4)) ifb ();

  hex_seg_display #(.NUM_DIGITS(2), .BLINK_DIV(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  hex_seg_display #(.NUM_DIGITS(4), .BLINK_DIV(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every falling edge, retire expectations due at the edge just taken.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      act = (cur.dut != 0) ? ifb.seg_out : {16'h0000, ifa.seg_out};
      checks++;
      if (cur.due != cyc) begin
        errors++;
        $display("FAIL %s: expectation due at cycle %0d not checked until cycle %0d", cur.tag, cur.due, cyc);
      end else if (act !== cur.val) begin
        errors++;
        $display("FAIL %s: seg_out got %h expected %h (cycle %0d)", cur.tag, act, cur.val, cyc);
      end
    end
  end

  task automatic expect_a(input logic [15:0] v, input string tag);
    exp_t e;
    e.due = cyc + 1;
    e.dut = 0;
    e.val = {16'h0000, v};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_b(input logic [31:0] v, input string tag);
    exp_t e;
    e.due = cyc + 1;
    e.dut = 1;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] dp_vis;

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifa.load = 1'b1;
    ifa.data_in = 8'h5A;
    ifa.blank_lz = 1'b0;
    ifa.blink_en = 1'b0;
    ifa.blink_mask = '0;
    ifb.load = 1'b0;
    ifb.data_in = '0;
    ifb.blank_lz = 1'b0;
    ifb.blink_en = 1'b0;
    ifb.blink_mask = '0;
`ifdef HEX_SEG_DISPLAY_DP_EN
    ifa.dp_in = '0;
    ifb.dp_in = '0;
    dp_vis = 16'hF924;
`else
    dp_vis = 16'hF9A4;
`endif

    // Reset held two edges with a load pending
    expect_a(16'hFFFF, "rst_edge1"); tick();
    expect_a(16'hFFFF, "rst_edge2"); tick();
    rst = 1'b0;
    ifa.load = 1'b0;
    expect_a(16'hC0C0, "rst_release"); tick();

    // Load latency and hold
    ifa.load = 1'b1; ifa.data_in = 8'h3F;
    expect_a(16'hC0C0, "load_capture_edge"); tick();
    ifa.load = 1'b0; ifa.data_in = 8'h11;
    expect_a(16'hB08E, "load_second_edge"); tick();
    expect_a(16'hB08E, "load_hold"); tick();

    // Leading-zero blanking
    ifa.blank_lz = 1'b1;
    ifa.load = 1'b1; ifa.data_in = 8'h07;
    expect_a(16'hB08E, "lz_prev"); tick();
    ifa.load = 1'b0;
    expect_a(16'hFFF8, "lz_07"); tick();
    ifa.load = 1'b1; ifa.data_in = 8'h00;
    expect_a(16'hFFF8, "lz_07_hold"); tick();
    ifa.load = 1'b0;
    expect_a(16'hFFC0, "lz_00"); tick();
    ifa.load = 1'b1; ifa.data_in = 8'h70;
    expect_a(16'hFFC0, "lz_00_hold"); tick();
    ifa.load = 1'b0;
    expect_a(16'hF8C0, "lz_70"); tick();

    // Back-to-back loads: last one wins
    ifa.load = 1'b1; ifa.data_in = 8'hAA;
    expect_a(16'hF8C0, "b2b_prev"); tick();
    ifa.data_in = 8'h12;
    expect_a(16'h8888, "b2b_first"); tick();
    ifa.load = 1'b0;
    expect_a(16'hF9A4, "b2b_last"); tick();

    // Blink high digit, half-period of 4 edges
    ifa.blank_lz = 1'b0;
    ifa.blink_mask = 2'b10;
    ifa.blink_en = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      expect_a((((e - 1) / 4) % 2) != 0 ? 16'hFFA4 : 16'hF9A4, "blink_hi");
      tick();
    end
    ifa.blink_en = 1'b0;
    expect_a(16'hFFA4, "unblink_edge1"); tick();
    expect_a(16'hF9A4, "unblink_edge2"); tick();
    expect_a(16'hF9A4, "unblink_hold"); tick();

    // Blink beats leading-zero blank; reset mid-blink restarts visible
    ifa.blank_lz = 1'b1;
    ifa.blink_mask = 2'b11;
    ifa.load = 1'b1; ifa.data_in = 8'h05;
    ifa.blink_en = 1'b1;
    expect_a(16'hF9A4, "prio_pre"); tick();
    ifa.load = 1'b0;
    expect_a(16'hFF92, "prio_vis1"); tick();
    expect_a(16'hFF92, "prio_vis2"); tick();
    expect_a(16'hFF92, "prio_vis3"); tick();
    expect_a(16'hFFFF, "prio_blinked"); tick();
    expect_a(16'hFFFF, "prio_blinked2"); tick();
    rst = 1'b1;
    expect_a(16'hFFFF, "rst_mid_blink"); tick();
    rst = 1'b0;
    expect_a(16'hFFC0, "restart_vis1"); tick();
    expect_a(16'hFFC0, "restart_vis2"); tick();
    expect_a(16'hFFC0, "restart_vis3"); tick();
    expect_a(16'hFFC0, "restart_vis4"); tick();
    expect_a(16'hFFFF, "restart_hidden"); tick();

    // Low-digit mask only, then decimal point load and blink
    ifa.blink_en = 1'b0;
    ifa.blank_lz = 1'b0;
    ifa.blink_mask = 2'b01;
    ifa.load = 1'b1; ifa.data_in = 8'h12;
`ifdef HEX_SEG_DISPLAY_DP_EN
    ifa.dp_in = 2'b01;
`endif
    expect_a(16'hC0FF, "mask_lo_hidden"); tick();
    ifa.load = 1'b0;
    expect_a(dp_vis, "dp_load"); tick();
    ifa.blink_en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      expect_a(dp_vis, "dp_visible");
      tick();
    end
    expect_a(16'hF9FF, "dp_blink_lo"); tick();
    ifa.blink_en = 1'b0;

    // Four-digit instance, BLINK_DIV=1
    rst = 1'b1;
    expect_b(32'hFFFFFFFF, "b_rst"); tick();
    rst = 1'b0;
    ifb.blank_lz = 1'b1;
    ifb.load = 1'b1; ifb.data_in = 16'h00A0;
    expect_b(32'hFFFFFFC0, "b_lz_zero"); tick();
    ifb.load = 1'b0;
    expect_b(32'hFFFF88C0, "b_lz_00A0"); tick();
    ifb.blink_mask = 4'b0010;
    ifb.blink_en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      expect_b((e % 2) != 0 ? 32'hFFFF88C0 : 32'hFFFFFFC0, "b_blink_div1");
      tick();
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
